// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, decode opcodes and fetch FSM states
package instruction_fetch_pkg;
  localparam int RISC_V_DATA_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and single-outstanding imem fetch with redirect squash
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = RISC_V_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic                  fetch_misalign
);
  fetch_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pc;
  logic capture;
  assign imem_req_valid = state == REQ;
  assign imem_addr = pc;
  assign capture = state == WAIT && imem_rsp_valid && !redirect_valid;
  // A redirect after the old address was accepted must drain the stale response
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = REQ;
      REQ:     state_n = imem_req_ready ? (redirect_valid ? DRAIN : WAIT) : REQ;
      WAIT:    state_n = imem_rsp_valid ? (redirect_valid ? REQ : HOLD) : (redirect_valid ? DRAIN : WAIT);
      HOLD:    state_n = (inst_ready || redirect_valid) ? REQ : HOLD;
      DRAIN:   state_n = (imem_rsp_valid && !redirect_valid) ? REQ : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      instruction    <= '0;
      inst_pc        <= '0;
      inst_valid     <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_n;
      fetch_misalign <= redirect_valid && |redirect_pc[1:0];
      if (redirect_valid) begin
        pc         <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        inst_valid <= 1'b0;
      end else if (capture) begin
        pc          <= pc + ADDR_WIDTH'(4);
        instruction <= imem_rsp_data;
        inst_pc     <= pc;
        inst_valid  <= 1'b1;
      end else if (state == HOLD && inst_ready) begin
        inst_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized fetch bench with memory/reference model and scoreboard
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 0, rst = 0;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, redirect_valid = 0;
  logic inst_valid, inst_ready = 0, fetch_misalign;
  logic [31:0] imem_addr, imem_rsp_data = 0, redirect_pc = 0, instruction, inst_pc;
  int passed = 0, total = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc, mem_addr, held_data, held_pc;
  bit mem_busy, mem_stale, orphan, held_valid, exp_mis, idle;
  int mem_cnt, mem_delay, stall;
  int k_ready, k_inst, k_delay, p_redir;

  instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction(instruction), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a == RPC ? 32'h00A00093 : (a * 32'h9E3779B1) ^ 32'h13;
  endfunction

  function automatic bit pick(int k);
    return k == 2 ? 1'($urandom_range(0, 1)) : k != 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic model_reset();
    mem_busy = 0;
    held_valid = 0;
    held_data = 0;
    held_pc = 0;
    exp_pc = RPC;
    exp_mis = 0;
    idle = 1;
  endtask

  // One cycle: check outputs against the model, drive inputs, predict the coming edge
  task automatic step(input bit k_rst, input bit f_redir, input logic [31:0] f_rpc);
    bit deliver, acc, consume, rd;
    logic [31:0] rpc;
    @(negedge clk);
    chk("imem_addr", imem_addr, exp_pc);
    chk("req_valid", 32'(imem_req_valid), 32'(!idle && !mem_busy && !held_valid));
    chk("inst_valid", 32'(inst_valid), 32'(held_valid));
    chk("instruction", instruction, held_data);
    chk("inst_pc", inst_pc, held_pc);
    chk("misalign", 32'(fetch_misalign), 32'(exp_mis));
    stall = (imem_req_valid || inst_valid) ? 0 : stall + 1;
    chk("stall_bound", 32'(stall > 64), 0);
    deliver = (mem_busy || orphan) && mem_cnt >= mem_delay;
    if ((mem_busy || orphan) && !deliver) mem_cnt++;
    rst = k_rst;
    imem_rsp_valid = deliver;
    imem_rsp_data = (deliver && mem_busy && !mem_stale) ? mem_word(mem_addr) : ($urandom | 32'h8000_0000);
    imem_req_ready = !orphan && pick(k_ready);
    inst_ready = pick(k_inst);
    rd = f_redir || $urandom_range(0, 99) < p_redir;
    if (mem_busy && mem_stale && deliver) rd = 0;
    rpc = f_redir ? f_rpc : ($urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
    redirect_valid = rd && !k_rst;
    redirect_pc = rpc;
    if (k_rst) begin
      orphan = (orphan || mem_busy) && !deliver;
      model_reset();
      return;
    end
    acc = imem_req_valid && imem_req_ready;
    consume = held_valid && inst_ready && !rd;
    idle = 0;
    if (orphan && deliver) orphan = 0;
    else if (mem_busy && deliver) begin
      mem_busy = 0;
      if (!mem_stale && !rd) begin
        held_valid = 1;
        held_data = mem_word(mem_addr);
        held_pc = mem_addr;
        exp_pc = mem_addr + 32'd4;
        sb_q.push_back({mem_addr, held_data});
      end
    end
    if (consume) held_valid = 0;
    if (acc) begin
      mem_busy = 1;
      mem_addr = imem_addr;
      mem_stale = rd;
      mem_cnt = 0;
      mem_delay = k_delay < 0 ? $urandom_range(0, 3) : k_delay;
    end
    exp_mis = rd && |rpc[1:0];
    if (rd) begin
      exp_pc = {rpc[31:2], 2'b00};
      held_valid = 0;
      if (mem_busy) mem_stale = 1;
    end
  endtask

  // Scoreboard monitor: every newly presented instruction must match the oldest expectation
  initial begin
    bit prev;
    logic [63:0] e;
    prev = 0;
    forever begin
      @(posedge clk);
      #2;
      if (inst_valid && !prev) begin
        if (sb_q.size() == 0) chk("unexpected_inst", 32'(inst_valid), 0);
        else begin
          e = sb_q.pop_front();
          chk("sb_data", instruction, e[31:0]);
          chk("sb_pc", inst_pc, e[63:32]);
        end
      end
      prev = inst_valid;
    end
  end

  initial begin
    bit seen;
    orphan = 0;
    stall = 0;
    mem_cnt = 0;
    mem_delay = 0;
    mem_stale = 0;
    mem_addr = 0;
    model_reset();
    k_ready = 1; k_inst = 1; k_delay = 0; p_redir = 0;
    #1 rst = 1;
    repeat (3) step(1, 0, 0);
    repeat (12) step(0, 0, 0);
    k_inst = 0;
    for (int i = 0; i < 50 && !held_valid; i++) step(0, 0, 0);
    chk("reach_hold", 32'(held_valid), 1);
    repeat (5) step(0, 0, 0);
    k_inst = 1;
    repeat (4) step(0, 0, 0);
    k_delay = 3;
    for (int i = 0; i < 50 && !(mem_busy && !mem_stale && mem_cnt == 0 && mem_delay == 3); i++) step(0, 0, 0);
    chk("reach_wait", 32'(mem_busy && mem_delay == 3), 1);
    step(0, 0, 0);
    step(0, 1, 32'h200);
    k_delay = 0;
    repeat (10) step(0, 0, 0);
    for (int i = 0; i < 50 && !held_valid; i++) step(0, 0, 0);
    chk("reach_hold2", 32'(held_valid), 1);
    step(0, 1, 32'h202);
    repeat (6) step(0, 0, 0);
    for (int i = 0; i < 50 && mem_busy; i++) step(0, 0, 0);
    step(0, 1, 32'hFFFF_FFFC);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(0, 0, 0);
      seen = imem_req_valid && imem_addr == 32'h0;
    end
    chk("wrap_to_zero", 32'(seen), 1);
    k_delay = 5;
    for (int i = 0; i < 50 && !(mem_busy && !mem_stale && mem_cnt == 0 && mem_delay == 5); i++) step(0, 0, 0);
    chk("reach_wait_rst", 32'(mem_busy && mem_delay == 5), 1);
    k_delay = 0;
    repeat (2) step(1, 0, 0);
    repeat (15) step(0, 0, 0);
    k_ready = 2; k_inst = 2; k_delay = -1; p_redir = 6;
    repeat (3000) step($urandom_range(0, 299) == 0, 0, 0);
    k_ready = 1; k_inst = 1; k_delay = 0; p_redir = 0;
    repeat (20) step(0, 0, 0);
    @(posedge clk);
    #3;
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
